// File: rtl/idli_sqi_rbuf_if.sv
// ----------------------------------------------------------------------------
// idli_sqi_rbuf_if
// Slice-stream bundle between a producer and the SQI slice buffer.
//
// Parameters:
//   SLICE_W  bits per slice
//   SLICES   slices per word (power of two, >= 2)
//   CTR_W    width of the global slice counter
//
// Signals (named from the buffer's point of view):
//   i_sqi_ctr    global slice counter, SLICES-1 marks the last slice of a word
//   i_sqi_push   write i_sqi_slice at the pointer and advance
//   i_sqi_flush  abandon the current word, restart at slice 0 ascending
//   i_sqi_mode   0 = reverse (serpentine), 1 = in-order
//   i_sqi_slice  write data
//   o_sqi_slice  slice currently at the pointer (value being overwritten)
//   o_sqi_data   whole buffer, slice i at [i*SLICE_W +: SLICE_W]
//   o_sqi_vld    buffer holds a complete word written in the current mode
//
// Modports: master (producer/bench), slave (buffer).
// ----------------------------------------------------------------------------
interface idli_sqi_rbuf_if #(
   parameter int unsigned SLICE_W = 4,
   parameter int unsigned SLICES  = 4,
   parameter int unsigned CTR_W   = $clog2(SLICES)
) ();

   logic [CTR_W-1:0]          i_sqi_ctr;
   logic                      i_sqi_push;
   logic                      i_sqi_flush;
   logic                      i_sqi_mode;
   logic [SLICE_W-1:0]        i_sqi_slice;
   logic [SLICE_W-1:0]        o_sqi_slice;
   logic [SLICES*SLICE_W-1:0] o_sqi_data;
   logic                      o_sqi_vld;

   modport master (
      output i_sqi_ctr, i_sqi_push, i_sqi_flush, i_sqi_mode, i_sqi_slice,
      input  o_sqi_slice, o_sqi_data, o_sqi_vld
   );

   modport slave (
      input  i_sqi_ctr, i_sqi_push, i_sqi_flush, i_sqi_mode, i_sqi_slice,
      output o_sqi_slice, o_sqi_data, o_sqi_vld
   );

endinterface

// File: rtl/idli_sqi_rbuf_m.sv
// ----------------------------------------------------------------------------
// idli_sqi_rbuf_m
// Serpentine slice buffer for the SQI datapath. Holds one word of
// SLICES x SLICE_W bits, written one slice per push. Every push reads out
// the slice it overwrites, so in reverse mode the pointer sweeps up then
// down and the read order is the reverse of the write order, fully
// pipelined. Optional in-order (delay-line) mode, word-valid flag and
// synchronous flush. Priority: reset > flush > push.
//
// Ports:
//   i_sqi_gck  clock
//   i_sqi_rst  synchronous active-high reset
//   sqi        idli_sqi_rbuf_if.slave bundle (ctr/push/flush/mode/slice in,
//              slice/data/vld out)
//
// Build option:
//   IDLI_SQI_RBUF_INORDER_EN  when defined, i_sqi_mode is latched on flush
//                             and end of word, enabling in-order mode and
//                             mode switching. Undefined: reverse-only,
//                             i_sqi_mode ignored.
// ----------------------------------------------------------------------------
module idli_sqi_rbuf_m #(
   parameter int unsigned SLICE_W = 4,
   parameter int unsigned SLICES  = 4,
   parameter int unsigned CTR_W   = $clog2(SLICES)
) (
   input  logic                  i_sqi_gck,
   input  logic                  i_sqi_rst,
   idli_sqi_rbuf_if.slave        sqi
);

   typedef enum logic {DIR_ASC  = 1'b0, DIR_DSC    = 1'b1} dir_e;
   typedef enum logic {MODE_REV = 1'b0, MODE_INORD = 1'b1} mode_e;

   localparam logic [CTR_W-1:0] LAST = CTR_W'(SLICES - 1);

   logic [SLICES-1:0][SLICE_W-1:0] data_q, data_d;
   logic [CTR_W-1:0]               ptr_q, ptr_d;
   logic [CTR_W-1:0]               ptr_inc, ptr_dec;
   dir_e                           dir_q, dir_d;
   mode_e                          mode_q;
   logic                           vld_q, vld_d;
   logic                           eow;
   logic                           flip;

`ifdef IDLI_SQI_RBUF_INORDER_EN
   mode_e                          mode_d;
`endif

   // Pointer arithmetic wraps modulo SLICES explicitly so a wider CTR_W
   // override still stays inside the buffer.
   assign ptr_inc = (ptr_q == LAST)     ? '0   : ptr_q + CTR_W'(1);
   assign ptr_dec = (ptr_q == '0)       ? LAST : ptr_q - CTR_W'(1);

   assign eow  = sqi.i_sqi_push && (sqi.i_sqi_ctr == LAST);

   // At the end of an aligned word the pointer sits at an end of the buffer;
   // it holds there and the sweep reverses, so the next word reads back from
   // the slice just written.
   assign flip = eow && (((dir_q == DIR_ASC) && (ptr_q == LAST)) ||
                         ((dir_q == DIR_DSC) && (ptr_q == '0)));

   always_comb begin
      data_d = data_q;
      ptr_d  = ptr_q;
      dir_d  = dir_q;
      vld_d  = vld_q;
`ifdef IDLI_SQI_RBUF_INORDER_EN
      mode_d = mode_q;
`endif
      if (sqi.i_sqi_flush) begin
         ptr_d = '0;
         dir_d = DIR_ASC;
         vld_d = 1'b0;
`ifdef IDLI_SQI_RBUF_INORDER_EN
         mode_d = mode_e'(sqi.i_sqi_mode);
`endif
      end else if (sqi.i_sqi_push) begin
         data_d[ptr_q] = sqi.i_sqi_slice;

         if (mode_q == MODE_INORD) begin
            ptr_d = ptr_inc;
            dir_d = DIR_ASC;
         end else if (flip) begin
            dir_d = (dir_q == DIR_ASC) ? DIR_DSC : DIR_ASC;
         end else begin
            ptr_d = (dir_q == DIR_ASC) ? ptr_inc : ptr_dec;
         end

         if (eow) begin
`ifdef IDLI_SQI_RBUF_INORDER_EN
            // A mode change overrides the pointer update above: the word in
            // flight belongs to the old order, so restart cleanly at slice 0.
            mode_d = mode_e'(sqi.i_sqi_mode);
            if (mode_d != mode_q) begin
               ptr_d = '0;
               dir_d = DIR_ASC;
               vld_d = 1'b0;
            end else begin
               vld_d = 1'b1;
            end
`else
            vld_d = 1'b1;
`endif
         end
      end
   end

   always_ff @(posedge i_sqi_gck) begin
      if (i_sqi_rst) begin
         data_q <= '0;
         ptr_q  <= '0;
         dir_q  <= DIR_ASC;
         vld_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         ptr_q  <= ptr_d;
         dir_q  <= dir_d;
         vld_q  <= vld_d;
      end
   end

`ifdef IDLI_SQI_RBUF_INORDER_EN
   always_ff @(posedge i_sqi_gck) begin
      if (i_sqi_rst) begin
         mode_q <= MODE_REV;
      end else begin
         mode_q <= mode_d;
      end
   end
`else
   assign mode_q = MODE_REV;
`endif

   assign sqi.o_sqi_slice = data_q[ptr_q];
   assign sqi.o_sqi_data  = data_q;
   assign sqi.o_sqi_vld   = vld_q;

endmodule

// File: tb/tb_idli_sqi_rbuf_m.sv
// ----------------------------------------------------------------------------
// tb_idli_sqi_rbuf_m
// Self-checking bench for idli_sqi_rbuf_m with SLICE_W=4, SLICES=4.
// Expected read-out slices are queued as each push is driven and compared
// mid-cycle while the push is on the bus; buffer contents and the valid
// flag are compared against hand-derived constants after each step.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_idli_sqi_rbuf_m;

   logic clk;
   logic rst;

   int unsigned n_cmp;
   int unsigned n_err;

   logic [3:0] exp_q[$];

   idli_sqi_rbuf_if #(.SLICE_W(4), .SLICES(4)) sqi ();

   idli_sqi_rbuf_m #(.SLICE_W(4), .SLICES(4)) dut (
      .i_sqi_gck (clk),
      .i_sqi_rst (rst),
      .sqi       (sqi.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Read-side monitor: every accepted push must show the queued slice.
   always @(negedge clk) begin
      if (sqi.i_sqi_push && !sqi.i_sqi_flush && !rst) begin
         if (exp_q.size() == 0) begin
            check("sb_empty", 32'(exp_q.size()), 32'd1);
         end else begin
            check("rd_slice", 32'(sqi.o_sqi_slice), 32'(exp_q.pop_front()));
         end
      end
   end

   task automatic push(input logic [3:0] d, input logic [1:0] c,
                       input logic [3:0] exp_rd, input logic m = 1'b0);
      exp_q.push_back(exp_rd);
      sqi.i_sqi_push  = 1'b1;
      sqi.i_sqi_flush = 1'b0;
      sqi.i_sqi_ctr   = c;
      sqi.i_sqi_slice = d;
      sqi.i_sqi_mode  = m;
      @(posedge clk); #1;
      sqi.i_sqi_push  = 1'b0;
   endtask

   task automatic idle(input int unsigned n);
      sqi.i_sqi_push  = 1'b0;
      sqi.i_sqi_flush = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   // Flush with push asserted and junk data: the write must be dropped.
   task automatic flush_cyc(input logic m = 1'b0);
      sqi.i_sqi_push  = 1'b1;
      sqi.i_sqi_flush = 1'b1;
      sqi.i_sqi_slice = 4'hF;
      sqi.i_sqi_ctr   = 2'd3;
      sqi.i_sqi_mode  = m;
      @(posedge clk); #1;
      sqi.i_sqi_push  = 1'b0;
      sqi.i_sqi_flush = 1'b0;
   endtask

   task automatic check_state(input string tag, input logic [15:0] data,
                              input logic vld, input logic [3:0] rd);
      check({tag, "_data"},  32'(sqi.o_sqi_data),  32'(data));
      check({tag, "_vld"},   32'(sqi.o_sqi_vld),   32'(vld));
      check({tag, "_slice"}, 32'(sqi.o_sqi_slice), 32'(rd));
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst             = 1'b1;
      sqi.i_sqi_push  = 1'b0;
      sqi.i_sqi_flush = 1'b0;
      sqi.i_sqi_mode  = 1'b0;
      sqi.i_sqi_ctr   = '0;
      sqi.i_sqi_slice = '0;
      repeat (2) @(posedge clk);
      #1;
      check_state("reset", 16'h0000, 1'b0, 4'h0);
      rst = 1'b0;

      // Reverse mode: first word, then read back in reverse order.
      push(4'h1, 2'd0, 4'h0);
      push(4'h2, 2'd1, 4'h0);
      push(4'h3, 2'd2, 4'h0);
      push(4'h4, 2'd3, 4'h0);
      check_state("word1", 16'h4321, 1'b1, 4'h4);
      push(4'h5, 2'd0, 4'h4);
      push(4'h6, 2'd1, 4'h3);
      push(4'h7, 2'd2, 4'h2);
      push(4'h8, 2'd3, 4'h1);
      check_state("word2", 16'h5678, 1'b1, 4'h8);

      // Push gap at ptr 2: everything holds, then the word completes.
      push(4'h9, 2'd0, 4'h8);
      push(4'hA, 2'd1, 4'h7);
      idle(3);
      check_state("gap", 16'h56A9, 1'b1, 4'h6);
      push(4'hB, 2'd2, 4'h6);
      push(4'hC, 2'd3, 4'h5);
      check_state("word3", 16'hCBA9, 1'b1, 4'hC);

      // Flush at ptr 2 descending, with push high.
      push(4'h1, 2'd0, 4'hC);
      flush_cyc();
      check_state("flush", 16'h1BA9, 1'b0, 4'h9);
      push(4'h2, 2'd0, 4'h9);
      check("flush_wr0", 32'(sqi.o_sqi_data), 32'h1BA2);
      push(4'h3, 2'd1, 4'hA);
      push(4'h4, 2'd2, 4'hB);
      push(4'h5, 2'd3, 4'h1);
      check_state("word4", 16'h5432, 1'b1, 4'h5);

      // Misaligned counter: ptr 3 ascending with ctr 1 wraps to 0.
      flush_cyc();
      push(4'h6, 2'd0, 4'h2);
      push(4'h7, 2'd1, 4'h3);
      push(4'h8, 2'd2, 4'h4);
      push(4'h9, 2'd1, 4'h5);
      check_state("wrap", 16'h9876, 1'b0, 4'h6);
      push(4'hA, 2'd3, 4'h6);
      check_state("wrap_eow", 16'h987A, 1'b1, 4'h7);
      push(4'hB, 2'd0, 4'h7);

      // Reset mid-word with push high discards everything.
      sqi.i_sqi_push  = 1'b1;
      sqi.i_sqi_slice = 4'hF;
      sqi.i_sqi_ctr   = 2'd1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      sqi.i_sqi_push  = 1'b0;
      check_state("rst_mid", 16'h0000, 1'b0, 4'h0);
      push(4'h3, 2'd0, 4'h0);
      check("rst_wr0", 32'(sqi.o_sqi_data), 32'h0003);
      push(4'h4, 2'd1, 4'h0);
      push(4'h5, 2'd2, 4'h0);

`ifdef IDLI_SQI_RBUF_INORDER_EN
      // Mode change to in-order at end of word: pointer restarts, valid drops.
      push(4'h6, 2'd3, 4'h0, 1'b1);
      check_state("mode_chg", 16'h6543, 1'b0, 4'h3);
      push(4'hA, 2'd0, 4'h3, 1'b1);
      push(4'hB, 2'd1, 4'h4, 1'b1);
      push(4'hC, 2'd2, 4'h5, 1'b1);
      push(4'hD, 2'd3, 4'h6, 1'b1);
      check_state("inord1", 16'hDCBA, 1'b1, 4'hA);
      push(4'hE, 2'd0, 4'hA, 1'b1);
      push(4'hF, 2'd1, 4'hB, 1'b1);
      push(4'h1, 2'd2, 4'hC, 1'b1);
      push(4'h2, 2'd3, 4'hD, 1'b1);
      check_state("inord2", 16'h21FE, 1'b1, 4'hE);
      push(4'h3, 2'd0, 4'hE, 1'b1);
`else
      // Mode input ignored: the word completes in reverse mode.
      push(4'h6, 2'd3, 4'h0, 1'b1);
      check_state("mode_ign", 16'h6543, 1'b1, 4'h6);
      push(4'h7, 2'd0, 4'h6, 1'b1);
      push(4'h8, 2'd1, 4'h5, 1'b1);
`endif

      idle(1);
      check("sb_drain", 32'(exp_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
